m_tile_drain: RTL and testbench

//  Downstream of the elementwise scale/bias stage. Captures each FP16 output tile (ROWS x COLS) from that stage.

---
 rtl/m_tile_drain_pkg.sv | 12 +
 rtl/m_tile_drain_buf.sv | 33 +++
 rtl/m_tile_drain.sv | 88 ++++++++
 tb/tb_m_tile_drain.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_tile_drain_pkg.sv
// Shared tile geometry and FP16 container types for the matrix output path.
package m_tile_drain_pkg;

  localparam int MPERow       = 4;
  localparam int MPECol       = 4;
  localparam int TileBufDepth = 2;

  typedef logic [15:0] fp16_t;
  typedef fp16_t [MPECol-1:0] mrow_t;
  typedef mrow_t [MPERow-1:0] mtile_t;

endpackage

// File: rtl/m_tile_drain_buf.sv
// Two-entry tile register file: whole-tile write, single-row combinational read.
module m_tile_buf
  import m_tile_drain_pkg::*;
#(
  parameter int ROWS = MPERow,
  parameter int COLS = MPECol,
  parameter int DW   = 16,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int RowW  = COLS * DW,
  localparam int TileW = ROWS * RowW
) (
  input  logic             clk,
  input  logic             we,
  input  logic             waddr,
  input  logic [TileW-1:0] wdata,
  input  logic             raddr,
  input  logic [RW-1:0]    rrow,
  output logic [RowW-1:0]  rdata
);

  logic [TileW-1:0] mem [TileBufDepth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = mem[raddr][int'(rrow) * RowW +: RowW];
  end

endmodule

// File: rtl/m_tile_drain.sv
// Ping-pong tile buffer draining one row per beat; row 0 visible the cycle after a tile lands in an empty buffer.
// Absorbs out_ready stalls with two tiles held; a tile offered while both entries are full is dropped and flagged.
module m_tile_drain
  import m_tile_drain_pkg::*;
#(
  parameter int ROWS = MPERow,
  parameter int COLS = MPECol,
  parameter int DW   = 16,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int RowW  = COLS * DW,
  localparam int TileW = ROWS * RowW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tile_in_valid,
  input  logic [TileW-1:0] tile_in,
  output logic             tile_in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RowW-1:0]  out_data,
  output logic [RW-1:0]    out_row,
  output logic             out_last,
  output logic             overflow
);

  logic [1:0]    cnt;
  logic          wp;
  logic          rp;
  logic [RW-1:0] row;
  logic          accept;
  logic          beat;
  logic          release_tile;

  assign tile_in_ready = (cnt != 2'd2);
  assign out_valid     = (cnt != 2'd0);
  assign out_row       = row;
  assign out_last      = (row == RW'(ROWS - 1));

  assign accept        = tile_in_valid && tile_in_ready;
  assign beat          = out_valid && out_ready;
  assign release_tile  = beat && out_last;

  m_tile_buf #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DW   (DW)
  ) u_buf (
    .clk   (clk),
    .we    (accept && !rst),
    .waddr (wp),
    .wdata (tile_in),
    .raddr (rp),
    .rrow  (row),
    .rdata (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wp <= ~wp;
      end
      if (tile_in_valid && !tile_in_ready) begin
        overflow <= 1'b1;
      end
      if (beat) begin
        if (out_last) begin
          row <= '0;
          rp  <= ~rp;
        end else begin
          row <= row + 1'b1;
        end
      end
      // Simultaneous accept and release leaves the occupancy unchanged.
      case ({accept, release_tile})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_m_tile_drain.sv
// Self-checking bench for m_tile_drain: directed vector table, corner sequences, randomized run against a queue model.
module tb_m_tile_drain;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 16;
  localparam int RowW  = COLS * DW;
  localparam int TileW = ROWS * RowW;

  logic             clk = 1'b0;
  logic             rst;
  logic             tile_in_valid;
  logic [TileW-1:0] tile_in;
  logic             tile_in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [RowW-1:0]  out_data;
  logic [1:0]       out_row;
  logic             out_last;
  logic             overflow;

  m_tile_drain #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .tile_in_valid (tile_in_valid),
    .tile_in       (tile_in),
    .tile_in_ready (tile_in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_last      (out_last),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Tile k holds 16'h3C00 + k*16 + r*4 + c at element (r,c).
  function automatic logic [TileW-1:0] mk_tile(input int k);
    logic [TileW-1:0] t;
    t = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        t[(r*COLS + c)*DW +: DW] = 16'(32'h3C00 + k*16 + r*4 + c);
    return t;
  endfunction

  function automatic logic [RowW-1:0] tile_row(input int k, input int r);
    logic [TileW-1:0] t;
    t = mk_tile(k);
    return t[r*RowW +: RowW];
  endfunction

  // Behavioural model: a queue of held tiles, a row cursor into the head tile, and a sticky drop flag.
  logic [TileW-1:0] mq[$];
  int               mrow;
  bit               movf;

  task automatic model_cmp(input string tag);
    chk({tag, ".valid"}, out_valid, mq.size() != 0);
    chk({tag, ".ready"}, tile_in_ready, mq.size() != 2);
    chk({tag, ".ovf"}, overflow, movf);
    if (mq.size() != 0) begin
      chk({tag, ".row"}, out_row, mrow);
      chk({tag, ".last"}, out_last, mrow == ROWS - 1);
      chk({tag, ".data"}, out_data, mq[0][mrow*RowW +: RowW]);
    end
  endtask

  task automatic cycle(input bit r, input bit tv, input logic [TileW-1:0] t, input bit ordy,
                       input string tag);
    bit fire;
    bit full;
    model_cmp(tag);
    rst           = r;
    tile_in_valid = tv;
    tile_in       = t;
    out_ready     = ordy;
    @(posedge clk);
    if (r) begin
      mq.delete();
      mrow = 0;
      movf = 0;
    end else begin
      fire = (mq.size() != 0) && ordy;
      full = (mq.size() == 2);
      if (fire) begin
        if (mrow == ROWS - 1) begin
          void'(mq.pop_front());
          mrow = 0;
        end else begin
          mrow++;
        end
      end
      if (tv) begin
        if (full) movf = 1;
        else mq.push_back(t);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tile_in_valid = 1'b0; tile_in = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); mrow = 0; movf = 0;
    chk("reset.valid", out_valid, 0);
    chk("reset.ready", tile_in_ready, 1);
    chk("reset.row", out_row, 0);
    chk("reset.last", out_last, 0);
    chk("reset.ovf", overflow, 0);
  endtask

  typedef struct {
    bit tv; int tk; bit ordy;
    bit e_vld; bit e_rdy; int e_row; bit e_last; int e_tk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit tv, input int tk, input bit ordy,
                     input bit ev, input bit er, input int erow, input bit el, input int etk);
    vec_t v;
    v.tv = tv; v.tk = tk; v.ordy = ordy;
    v.e_vld = ev; v.e_rdy = er; v.e_row = erow; v.e_last = el; v.e_tk = etk;
    tbl.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TileW-1:0] rt;
    bit rr, rv, ro;

    // Single tile: accept, then four beats on consecutive cycles.
    add(1, 0, 1,  0, 1, 0, 0, 0);
    add(0, 0, 1,  1, 1, 0, 0, 0);
    add(0, 0, 1,  1, 1, 1, 0, 0);
    add(0, 0, 1,  1, 1, 2, 0, 0);
    add(0, 0, 1,  1, 1, 3, 1, 0);
    // Two tiles back to back: buffer full until tile 1 releases, then tile 2 with no bubble.
    add(1, 1, 1,  0, 1, 0, 0, 0);
    add(1, 2, 1,  1, 1, 0, 0, 1);
    add(0, 0, 1,  1, 0, 1, 0, 1);
    add(0, 0, 1,  1, 0, 2, 0, 1);
    add(0, 0, 1,  1, 0, 3, 1, 1);
    add(0, 0, 1,  1, 1, 0, 0, 2);
    add(0, 0, 1,  1, 1, 1, 0, 2);
    add(0, 0, 1,  1, 1, 2, 0, 2);
    add(0, 0, 1,  1, 1, 3, 1, 2);
    add(0, 0, 1,  0, 1, 0, 0, 0);

    do_reset();
    chk("row0.pattern", tile_row(0, 0), {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00});

    foreach (tbl[i]) begin
      chk($sformatf("vec%0d.valid", i), out_valid, tbl[i].e_vld);
      chk($sformatf("vec%0d.ready", i), tile_in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d.ovf", i), overflow, 0);
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d.row", i), out_row, tbl[i].e_row);
        chk($sformatf("vec%0d.last", i), out_last, tbl[i].e_last);
        chk($sformatf("vec%0d.data", i), out_data, tile_row(tbl[i].e_tk, tbl[i].e_row));
      end
      tile_in_valid = tbl[i].tv;
      tile_in       = mk_tile(tbl[i].tk);
      out_ready     = tbl[i].ordy;
      @(posedge clk); #1;
    end

    // Stall at row 2 for ten cycles: presented row must hold.
    do_reset();
    cycle(0, 1, mk_tile(3), 1, "stall.in");
    cycle(0, 0, '0, 1, "stall.r0");
    cycle(0, 0, '0, 1, "stall.r1");
    for (int i = 0; i < 10; i++) begin
      chk("stall.frozen_row", out_row, 2);
      chk("stall.frozen_data", out_data, tile_row(3, 2));
      chk("stall.frozen_valid", out_valid, 1);
      cycle(0, 0, '0, 0, "stall.hold");
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, "stall.resume");

    // Overflow: third tile dropped, flag sticky, only two tiles streamed.
    cycle(0, 1, mk_tile(4), 0, "ovf.t4");
    cycle(0, 1, mk_tile(5), 0, "ovf.t5");
    cycle(0, 1, mk_tile(6), 0, "ovf.t6");
    chk("ovf.flag", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf.stream", out_data, tile_row(4 + i / 4, i % 4));
      cycle(0, 0, '0, 1, "ovf.drain");
    end
    chk("ovf.sticky", overflow, 1);
    chk("ovf.empty", out_valid, 0);

    // New tile arriving on the releasing beat of a single held tile.
    do_reset();
    cycle(0, 1, mk_tile(7), 1, "lastacc.in");
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, "lastacc.beat");
    chk("lastacc.pre_last", out_last, 1);
    cycle(0, 1, mk_tile(8), 1, "lastacc.swap");
    chk("lastacc.row0", out_row, 0);
    chk("lastacc.data", out_data, tile_row(8, 0));
    chk("lastacc.ready", tile_in_ready, 1);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, "lastacc.drain");

    // Reset mid-stream with overflow set.
    cycle(0, 1, mk_tile(9), 0, "rst.t9");
    cycle(0, 1, mk_tile(10), 0, "rst.t10");
    cycle(0, 1, mk_tile(11), 0, "rst.t11");
    cycle(0, 0, '0, 1, "rst.r0");
    chk("rst.at_row1", out_row, 1);
    cycle(1, 0, '0, 1, "rst.pulse");
    chk("rst.valid", out_valid, 0);
    chk("rst.ready", tile_in_ready, 1);
    chk("rst.ovf", overflow, 0);
    cycle(0, 1, mk_tile(12), 1, "rst.t12");
    chk("rst.new_row", out_row, 0);
    chk("rst.new_data", out_data, tile_row(12, 0));
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1, "rst.drain");

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int w = 0; w < TileW / 32; w++) rt[w*32 +: 32] = $urandom;
      rr = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 2) == 0);
      ro = ($urandom_range(0, 2) != 0);
      cycle(rr, rv, rt, ro, "rand");
    end
    cycle(0, 0, '0, 1, "rand.final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
